isp_test_pattern_gen: RTL
=========================

# isp_test_pattern_gen

Pixel-stream source for the ISP pipeline: generates RGB test frames and drives them into the first processing stage (e.g. saturation adjust) over the standard `valid`/`data[3]`/`user`/`ready` stream. It is the transmitting end of that stream. Its sole backpressure input is the downstream stage's `out_ready`, which connects to this block's `in_ready`. Used for bring-up, colour-pipeline verification and the no-sensor display mode.

## Interface
Parameters:
- `COLOR_DEPTH`, 8, bits per colour channel.
- `DIM_W`, 12, width of the frame-dimension configuration inputs.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  level; high = produce frames continuously.
- `cfg_width`  in  DIM_W  active pixels per line; values <8 treated as 8.
- `cfg_height`  in  DIM_W  lines per frame; 0 treated as 1.
- `cfg_vblank`  in  16  idle cycles between frames.
- `cfg_pattern`  in  2  0 colour bars, 1 solid, 2 checkerboard, 3 gradient.
- `cfg_color`  in  3×COLOR_DEPTH  solid colour, `{R,G,B}`.
- `out_valid`  out  1  pixel available.
- `out_data`  out  COLOR_DEPTH [3]  `[2]`=R, `[1]`=G, `[0]`=B.
- `out_user`  out  8  `[0]` SOF, `[1]` EOL, `[2]` EOF, `[7:3]` = 0.
- `in_ready`  in  1  downstream can accept.
- `busy`  out  1  high in any state other than IDLE.
- `frame_cnt`  out  16  completed frames, wraps at 0xFFFF→0.

## Operation
- States:
  - IDLE → ACTIVE when `enable`.
  - ACTIVE → VBLANK on acceptance of the EOF pixel.
  - VBLANK → ACTIVE when the blank counter reaches `cfg_vblank` and `enable`; → IDLE when it reaches `cfg_vblank` and `!enable`.
- `cfg_*` are latched on entry to ACTIVE and held for the whole frame. Mid-frame changes apply to the next frame only.
- Transfer = `out_valid && in_ready` at a posedge. While `out_valid && !in_ready`, `out_data` and `out_user` hold stable.
- Counters `x` (0..W-1) and `y` (0..H-1) advance only on transfer. On `x`==W-1, `x` wraps to 0 and `y` increments.
- Frame markers:
  - SOF on pixel (0,0).
  - EOL on `x`==W-1.
  - EOF on pixel (W-1,H-1), together with EOL.
  - W=8,H=1: pixel 0 carries SOF; pixel 7 carries EOL|EOF.
- Colour bars:
  - Bar width = W>>3. The bar index increments each time the bar counter wraps and saturates at 7, so remainder pixels stay black. The index resets each line.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - "Full" = all ones; "off" = 0.
- Checkerboard: white when `x[3]^y[3]`, else black.
- Solid: `cfg_color`.
- Gradient: all channels = `x[COLOR_DEPTH-1:0]`.
- `frame_cnt` increments on EOF transfer.
- `enable` falling mid-frame: the current frame completes normally, then VBLANK, then IDLE.

## Timing
- Reset values: `out_valid`=0, `out_data`=0 all channels, `out_user`=0, `busy`=0, `frame_cnt`=0, state IDLE.
- `enable` sampled high in IDLE at edge N → SOF pixel valid in the cycle after N.
- Throughput: 1 pixel/clk while `in_ready`=1. After a transfer at edge N, the next pixel is valid in the cycle after N.
- VBLANK:
  - After EOF transfer at edge N, `out_valid`=0 for exactly `cfg_vblank` cycles.
  - `cfg_vblank`=0: next SOF valid in the cycle after N, so there is no bubble.
- `in_ready` low during VBLANK or IDLE has no effect.
- `out_valid` never depends combinationally on `in_ready`; all outputs are registered.
- Reset asserted mid-frame: all outputs return to reset values at the next edge. The partial frame is abandoned and `frame_cnt` is not incremented.

## Configuration
- `ISP_TPG_GRADIENT_EN` defined: pattern 3 produces the gradient.
- `ISP_TPG_GRADIENT_EN` undefined: gradient logic is not built and pattern 3 produces colour bars.

## Structure
- Shared package `isp_stream_pkg`:
  - user-bit index constants `USER_SOF`=0, `USER_EOL`=1, `USER_EOF`=2;
  - `tpg_pattern_e` enum;
  - the state enum.
- One sub-module, `tpg_pixel_color`: combinational pattern/colour lookup from `x`, `y`, bar index and latched configuration. The parent owns the FSM, counters and output registers.

## Test plan
- W=16, H=2, pattern 0, `cfg_vblank`=0, `in_ready`=1 → 32 consecutive valid pixels.
  - Bars are 2 px each: px0-1 = (FF,FF,FF), px14-15 = (00,00,00).
  - SOF on px0, EOL on px15 and px31, EOF on px31.
  - `frame_cnt`=1 after px31.
- Same configuration with `in_ready` toggled 1,0,0,1… → data and user stable across stalls; identical pixel sequence; no drops or duplicates.
- W=20 bars → bar width 2, index saturates at 7; px14-19 are black.
- `cfg_vblank`=5 → exactly 5 invalid cycles between EOF transfer and next SOF. `enable` dropped mid-frame → frame completes, then `busy`=0.
- Reset asserted at px10 of frame 3 → next cycle `out_valid`=0, `frame_cnt`=0. Re-enable → fresh SOF at (0,0).
- Pattern 3, W=300 → `out_data` = `x` mod 256 with `ISP_TPG_GRADIENT_EN` defined; colour bars without it.

Source files
------------

// File: rtl/isp_stream_pkg.sv
// Shared definitions for the ISP pixel stream: user-bit positions, test pattern codes,
// generator FSM states and the colour-bar lookup.
package isp_stream_pkg;

  localparam int USER_SOF = 0;
  localparam int USER_EOL = 1;
  localparam int USER_EOF = 2;

  typedef enum logic [1:0] {
    PAT_BARS     = 2'd0,
    PAT_SOLID    = 2'd1,
    PAT_CHECKER  = 2'd2,
    PAT_GRADIENT = 2'd3
  } tpg_pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_VBLANK = 2'd2
  } tpg_state_e;

  // Per-channel on/off flags {R,G,B} for bars white..black, left to right.
  function automatic logic [2:0] bar_rgb_on(input logic [2:0] idx);
    logic [2:0] on;
    case (idx)
      3'd0:    on = 3'b111;
      3'd1:    on = 3'b110;
      3'd2:    on = 3'b011;
      3'd3:    on = 3'b010;
      3'd4:    on = 3'b101;
      3'd5:    on = 3'b100;
      3'd6:    on = 3'b001;
      default: on = 3'b000;
    endcase
    return on;
  endfunction

endpackage

// File: rtl/tpg_pixel_color.sv
// Combinational colour lookup for one pixel of the test pattern generator.
// Gradient is only built with ISP_TPG_GRADIENT_EN; otherwise pattern 3 falls back to colour bars.
module tpg_pixel_color
  import isp_stream_pkg::*;
#(
  parameter int COLOR_DEPTH = 8,
  parameter int DIM_W       = 12
) (
  input  logic [DIM_W-1:0]         x,
  input  logic [DIM_W-1:0]         y,
  input  logic [2:0]               bar_idx,
  input  tpg_pattern_e             pattern,
  input  logic [3*COLOR_DEPTH-1:0] color,
  output logic [3*COLOR_DEPTH-1:0] rgb
);

  logic [2:0]               bar_on_s;
  logic [3*COLOR_DEPTH-1:0] bar_rgb_s;
  logic                     unused_s;

  assign bar_on_s  = bar_rgb_on(bar_idx);
  assign bar_rgb_s = {{COLOR_DEPTH{bar_on_s[2]}}, {COLOR_DEPTH{bar_on_s[1]}}, {COLOR_DEPTH{bar_on_s[0]}}};
  assign unused_s  = ^{x, y};

  always_comb begin
    rgb = '0;
    case (pattern)
      PAT_SOLID:    rgb = color;
      PAT_CHECKER:  rgb = (x[3] ^ y[3]) ? {(3*COLOR_DEPTH){1'b1}} : {(3*COLOR_DEPTH){1'b0}};
`ifdef ISP_TPG_GRADIENT_EN
      PAT_GRADIENT: rgb = {3{x[COLOR_DEPTH-1:0]}};
`endif
      default:      rgb = bar_rgb_s;
    endcase
  end

endmodule

// File: rtl/isp_test_pattern_gen.sv
// RGB test-frame source driving the ISP valid/ready pixel stream; all outputs registered.
// Optional gradient pattern enabled by defining ISP_TPG_GRADIENT_EN.
module isp_test_pattern_gen
  import isp_stream_pkg::*;
#(
  parameter int COLOR_DEPTH = 8,
  parameter int DIM_W       = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [DIM_W-1:0]         cfg_width,
  input  logic [DIM_W-1:0]         cfg_height,
  input  logic [15:0]              cfg_vblank,
  input  logic [1:0]               cfg_pattern,
  input  logic [3*COLOR_DEPTH-1:0] cfg_color,
  output logic                     out_valid,
  output logic [COLOR_DEPTH-1:0]   out_data [3],
  output logic [7:0]               out_user,
  input  logic                     in_ready,
  output logic                     busy,
  output logic [15:0]              frame_cnt
);

  localparam int RGB_W = 3 * COLOR_DEPTH;

  tpg_state_e         state_q, state_d;
  logic [DIM_W-1:0]   x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d, bar_cnt_q, bar_cnt_d;
  logic [2:0]         bar_idx_q, bar_idx_d;
  logic [15:0]        vblank_q, vblank_d, blank_cnt_q, blank_cnt_d, frame_cnt_q, frame_cnt_d;
  tpg_pattern_e       pattern_q, pattern_d;
  logic [RGB_W-1:0]   color_q, color_d, out_rgb_q, out_rgb_d, pix_rgb_s;
  logic [7:0]         out_user_q, out_user_d;
  logic               out_valid_q, out_valid_d, busy_q, busy_d;
  logic               xfer_s, eof_xfer_s, blank_done_s, start_s, step_s, line_last_s, bar_last_s;
  logic [DIM_W-1:0]   w_eff_s, h_eff_s;

  assign xfer_s       = out_valid_q && in_ready;
  assign eof_xfer_s   = xfer_s && out_user_q[USER_EOF];
  assign blank_done_s = (blank_cnt_q == vblank_q);
  assign w_eff_s      = (cfg_width < DIM_W'(8)) ? DIM_W'(8) : cfg_width;
  assign h_eff_s      = (cfg_height == '0) ? DIM_W'(1) : cfg_height;
  assign line_last_s  = (x_q == (w_q - DIM_W'(1)));
  assign bar_last_s   = (bar_cnt_q == ((w_q >> 2'd3) - DIM_W'(1)));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_ACTIVE;
        else        state_d = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (eof_xfer_s && (vblank_q != 16'd0)) state_d = ST_VBLANK;
        else if (eof_xfer_s)                   state_d = enable ? ST_ACTIVE : ST_IDLE;
        else                                   state_d = ST_ACTIVE;
      end
      ST_VBLANK: begin
        if (blank_done_s) state_d = enable ? ST_ACTIVE : ST_IDLE;
        else              state_d = ST_VBLANK;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new frame starts whenever we enter ACTIVE, including back-to-back with zero blanking.
  assign start_s = (state_d == ST_ACTIVE) && ((state_q != ST_ACTIVE) || eof_xfer_s);
  assign step_s  = (state_q == ST_ACTIVE) && xfer_s && !out_user_q[USER_EOF];

  // Coordinates and frame configuration of the pixel to be presented next
  always_comb begin
    w_d = w_q; h_d = h_q; vblank_d = vblank_q; pattern_d = pattern_q; color_d = color_q;
    x_d = x_q; y_d = y_q; bar_idx_d = bar_idx_q; bar_cnt_d = bar_cnt_q;
    if (start_s) begin
      w_d = w_eff_s; h_d = h_eff_s; vblank_d = cfg_vblank;
      pattern_d = tpg_pattern_e'(cfg_pattern); color_d = cfg_color;
      x_d = '0; y_d = '0; bar_idx_d = 3'd0; bar_cnt_d = '0;
    end else if (step_s) begin
      if (line_last_s) begin
        x_d = '0; y_d = y_q + DIM_W'(1); bar_idx_d = 3'd0; bar_cnt_d = '0;
      end else if (bar_last_s) begin
        x_d = x_q + DIM_W'(1); bar_cnt_d = '0;
        bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
      end else begin
        x_d = x_q + DIM_W'(1); bar_cnt_d = bar_cnt_q + DIM_W'(1);
      end
    end else begin
      x_d = x_q;
    end
  end

  tpg_pixel_color #(
    .COLOR_DEPTH (COLOR_DEPTH),
    .DIM_W       (DIM_W)
  ) u_pixel_color (
    .x       (x_d),
    .y       (y_d),
    .bar_idx (bar_idx_d),
    .pattern (pattern_d),
    .color   (color_d),
    .rgb     (pix_rgb_s)
  );

  // Output stage, blanking and frame counters
  always_comb begin
    out_valid_d = out_valid_q; out_rgb_d = out_rgb_q; out_user_d = out_user_q;
    if (start_s || step_s) begin
      out_valid_d = 1'b1;
      out_rgb_d   = pix_rgb_s;
      out_user_d  = 8'd0;
      out_user_d[USER_SOF] = (x_d == '0) && (y_d == '0);
      out_user_d[USER_EOL] = (x_d == (w_d - DIM_W'(1)));
      out_user_d[USER_EOF] = (x_d == (w_d - DIM_W'(1))) && (y_d == (h_d - DIM_W'(1)));
    end else if (xfer_s) begin
      out_valid_d = 1'b0;
      out_user_d  = 8'd0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if ((state_q == ST_ACTIVE) && eof_xfer_s)       blank_cnt_d = 16'd1;
    else if ((state_q == ST_VBLANK) && !blank_done_s) blank_cnt_d = blank_cnt_q + 16'd1;
    else                                             blank_cnt_d = blank_cnt_q;
    if (eof_xfer_s) frame_cnt_d = frame_cnt_q + 16'd1;
    else            frame_cnt_d = frame_cnt_q;
    busy_d = (state_d != ST_IDLE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0; y_q <= '0; w_q <= DIM_W'(8); h_q <= DIM_W'(1); bar_cnt_q <= '0; bar_idx_q <= 3'd0;
      vblank_q <= 16'd0; blank_cnt_q <= 16'd0; frame_cnt_q <= 16'd0;
      pattern_q <= PAT_BARS; color_q <= '0; out_rgb_q <= '0; out_user_q <= 8'd0;
      out_valid_q <= 1'b0; busy_q <= 1'b0;
    end else begin
      x_q <= x_d; y_q <= y_d; w_q <= w_d; h_q <= h_d; bar_cnt_q <= bar_cnt_d; bar_idx_q <= bar_idx_d;
      vblank_q <= vblank_d; blank_cnt_q <= blank_cnt_d; frame_cnt_q <= frame_cnt_d;
      pattern_q <= pattern_d; color_q <= color_d; out_rgb_q <= out_rgb_d; out_user_q <= out_user_d;
      out_valid_q <= out_valid_d; busy_q <= busy_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data[2] = out_rgb_q[3*COLOR_DEPTH-1:2*COLOR_DEPTH];
  assign out_data[1] = out_rgb_q[2*COLOR_DEPTH-1:COLOR_DEPTH];
  assign out_data[0] = out_rgb_q[COLOR_DEPTH-1:0];
  assign out_user    = out_user_q;
  assign busy        = busy_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
